// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and FSM state type for the FIFO symbol packer
package fifo_pkg;

   localparam int FIFO_WIDTH_DEF  = 2;
   localparam int PACK_FACTOR_DEF = 4;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_packer.sv
// rtl/fifo_packer.sv - packs PACK_FACTOR FIFO symbols (LSB first) into one output word
module fifo_packer
   import fifo_pkg::*;
#(
   parameter int  FIFO_WIDTH  = FIFO_WIDTH_DEF,
   parameter int  PACK_FACTOR = PACK_FACTOR_DEF,
   localparam int OUT_WIDTH   = FIFO_WIDTH * PACK_FACTOR,
   localparam int CNT_WIDTH   = $clog2(PACK_FACTOR + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic [CNT_WIDTH-1:0]  out_count,
   output logic                  out_parity
);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
   logic                 out_parity_q, out_parity_d;

   // accumulator and count as they would look after this cycle's pop
   logic [OUT_WIDTH-1:0] acc_fill;
   logic [CNT_WIDTH-1:0] cnt_fill;

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and datapath next values; a word is sealed on a full pop or a non-empty flush
   always_comb begin
      acc_fill = acc_q;
      for (int s = 0; s < PACK_FACTOR; s++) begin
         if (fifo_rd_en && (sym_cnt_q == CNT_WIDTH'(s))) begin
            acc_fill[s*FIFO_WIDTH +: FIFO_WIDTH] = fifo_rd_data;
         end
      end
      cnt_fill = fifo_rd_en ? (sym_cnt_q + CNT_WIDTH'(1)) : sym_cnt_q;

      state_d      = state_q;
      sym_cnt_d    = sym_cnt_q;
      acc_d        = acc_q;
      out_data_d   = out_data_q;
      out_count_d  = out_count_q;
      out_parity_d = out_parity_q;

      case (state_q)
         FILL: begin
            acc_d     = acc_fill;
            sym_cnt_d = cnt_fill;
            if ((cnt_fill == CNT_WIDTH'(PACK_FACTOR)) || (flush && (cnt_fill != '0))) begin
               state_d      = HOLD;
               out_data_d   = acc_fill;
               out_count_d  = cnt_fill;
               out_parity_d = ^acc_fill;
               acc_d        = '0;
               sym_cnt_d    = '0;
            end
         end
         HOLD: begin
            // flush is deliberately not looked at here, so it cannot be remembered
            if (out_ready) begin
               state_d      = FILL;
               out_data_d   = '0;
               out_count_d  = '0;
               out_parity_d = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // datapath registers; reset drops any partial or held word
   always_ff @(posedge clk) begin
      if (reset) begin
         sym_cnt_q    <= '0;
         acc_q        <= '0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         out_parity_q <= 1'b0;
      end else begin
         sym_cnt_q    <= sym_cnt_d;
         acc_q        <= acc_d;
         out_data_q   <= out_data_d;
         out_count_q  <= out_count_d;
         out_parity_q <= out_parity_d;
      end
   end

   // outputs: pop only while filling, word visible only while holding
   always_comb begin
      fifo_rd_en = (state_q == FILL) && !fifo_empty && !reset;
      out_valid  = (state_q == HOLD);
      out_data   = out_data_q;
      out_count  = out_count_q;
      out_parity = out_parity_q;
   end

endmodule
